// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
// demux4_stream : 1-to-4 valid/ready stream distributor with one registered
//                 slot per output channel and saturating delivery counters.
// Revision      : 1.0
// ============================================================================
module demux4_stream #(
   parameter int N = 8,
   parameter int C = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   in_sel,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out0_data,
   output logic [N-1:0] out1_data,
   output logic [N-1:0] out2_data,
   output logic [N-1:0] out3_data,
   output logic         out0_valid,
   output logic         out1_valid,
   output logic         out2_valid,
   output logic         out3_valid,
   input  logic         out0_ready,
   input  logic         out1_ready,
   input  logic         out2_ready,
   input  logic         out3_ready,
   input  logic         cnt_clear,
   output logic [C-1:0] cnt0,
   output logic [C-1:0] cnt1,
   output logic [C-1:0] cnt2,
   output logic [C-1:0] cnt3
);

   localparam logic [C-1:0] c_CNT_MAX = {C{1'b1}};
   localparam logic [C-1:0] c_CNT_ONE = C'(1);

   logic [3:0]          w_out_ready;
   logic [3:0]          w_out_valid;
   logic [3:0]          w_sel_hot;
   logic                w_in_fire;
   logic [3:0][N-1:0]   w_out_data;
   logic [3:0][C-1:0]   w_cnt;

   assign w_out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};
   assign w_sel_hot   = 4'b0001 << in_sel;

   // A slot can take a word when empty or when its consumer drains it this cycle.
   assign in_ready  = ~w_out_valid[in_sel] | w_out_ready[in_sel];
   assign w_in_fire = in_valid & in_ready;

   generate
      for (genvar k = 0; k < 4; k++) begin : g_ch
         logic [N-1:0] data_q;
         logic [N-1:0] data_d;
         logic         valid_q;
         logic         valid_d;
         logic [C-1:0] cnt_q;
         logic [C-1:0] cnt_d;
         logic         w_load;
         logic         w_drain;

         assign w_load  = w_in_fire & w_sel_hot[k];
         assign w_drain = valid_q & w_out_ready[k];

         // Refill wins over drain so a same-cycle drain+load keeps the slot full.
         always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (w_load) begin
               data_d  = in_data;
               valid_d = 1'b1;
            end else if (w_drain) begin
               valid_d = 1'b0;
            end
         end

         always_comb begin
            cnt_d = cnt_q;
            if (cnt_clear) begin
               cnt_d = '0;
            end else if (w_drain && (cnt_q != c_CNT_MAX)) begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q  <= '0;
               valid_q <= 1'b0;
               cnt_q   <= '0;
            end else begin
               data_q  <= data_d;
               valid_q <= valid_d;
               cnt_q   <= cnt_d;
            end
         end

         assign w_out_valid[k] = valid_q;
         assign w_out_data[k]  = data_q;
         assign w_cnt[k]       = cnt_q;
      end
   endgenerate

   assign out0_data  = w_out_data[0];
   assign out1_data  = w_out_data[1];
   assign out2_data  = w_out_data[2];
   assign out3_data  = w_out_data[3];
   assign out0_valid = w_out_valid[0];
   assign out1_valid = w_out_valid[1];
   assign out2_valid = w_out_valid[2];
   assign out3_valid = w_out_valid[3];
   assign cnt0       = w_cnt[0];
   assign cnt1       = w_cnt[1];
   assign cnt2       = w_cnt[2];
   assign cnt3       = w_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
// tb_demux4_stream : directed stimulus with a per-cycle occupancy model.
// Revision         : 1.0
// ============================================================================
module tb_demux4_stream;

   localparam int N    = 8;
   localparam int C    = 2;
   localparam int CMAX = (1 << C) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] in_data = '0;
   logic [1:0]   in_sel = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   ordy = '0;
   logic         cnt_clear = 1'b0;
   logic [N-1:0] od [4];
   logic [3:0]   ov;
   logic [C-1:0] oc [4];

   int total = 0;
   int bad   = 0;
   bit en    = 1'b0;

   // Model: each channel is either occupied or not, with the last word loaded.
   bit           m_full [4];
   logic [N-1:0] m_data [4];
   int           m_cnt  [4];

   always #5 clk = ~clk;

   demux4_stream #(.N(N), .C(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (od[0]),
      .out1_data  (od[1]),
      .out2_data  (od[2]),
      .out3_data  (od[3]),
      .out0_valid (ov[0]),
      .out1_valid (ov[1]),
      .out2_valid (ov[2]),
      .out3_valid (ov[3]),
      .out0_ready (ordy[0]),
      .out1_ready (ordy[1]),
      .out2_ready (ordy[2]),
      .out3_ready (ordy[3]),
      .cnt_clear  (cnt_clear),
      .cnt0       (oc[0]),
      .cnt1       (oc[1]),
      .cnt2       (oc[2]),
      .cnt3       (oc[3])
   );

   function automatic bit m_ready(input logic [1:0] s);
      return !m_full[s] || ordy[s];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_full[k] <= 1'b0;
            m_data[k] <= '0;
            m_cnt[k]  <= 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            bit drain;
            bit load;
            int nc;
            drain = m_full[k] && ordy[k];
            load  = in_valid && m_ready(in_sel) && (int'(in_sel) == k);
            nc    = m_cnt[k] + (drain ? 1 : 0);
            if (nc > CMAX) nc = CMAX;
            if (cnt_clear) nc = 0;
            m_cnt[k]  <= nc;
            m_full[k] <= load || (m_full[k] && !drain);
            if (load) m_data[k] <= in_data;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (en) begin
         chk("model_in_ready", in_ready, m_ready(in_sel));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("model_out%0d_valid", k), ov[k], m_full[k]);
            chk($sformatf("model_out%0d_data", k), od[k], m_data[k]);
            chk($sformatf("model_cnt%0d", k), oc[k], m_cnt[k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic v, input logic [1:0] s, input logic [N-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      // Reset asserted mid-cycle, effective immediately.
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_valid", ov[k], 0);
         chk("rst_data", od[k], 0);
         chk("rst_cnt", oc[k], 0);
      end
      step();
      step();
      rst = 1'b0;
      en  = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1 chk("idle_in_ready", in_ready, 1);
      end

      // Routing
      ordy = 4'hF;
      step(); send(1, 0, 8'h11); #1 chk("route_rdy", in_ready, 1);
      step(); send(1, 1, 8'h22); #1;
      chk("route_v0", ov[0], 1); chk("route_d0", od[0], 8'h11); chk("route_v1_early", ov[1], 0);
      step(); send(1, 2, 8'h33); #1;
      chk("route_v1", ov[1], 1); chk("route_d1", od[1], 8'h22);
      chk("route_v0_drained", ov[0], 0); chk("route_d0_hold", od[0], 8'h11);
      step(); send(1, 3, 8'h44); #1;
      chk("route_d2", od[2], 8'h33); chk("route_v3_early", ov[3], 0);
      step(); in_valid = 1'b0; #1;
      chk("route_d3", od[3], 8'h44); chk("route_v2_drained", ov[2], 0);
      step(); #1;
      chk("route_ov", ov, 4'h0);
      for (int k = 0; k < 4; k++) chk("route_cnt", oc[k], 1);

      // Backpressure on channel 2
      ordy = 4'b1011;
      send(1, 2, 8'hA5); #1 chk("bp_first_rdy", in_ready, 1);
      step(); send(1, 2, 8'h5A); #1;
      chk("bp_second_rdy", in_ready, 0); chk("bp_v2", ov[2], 1); chk("bp_d2", od[2], 8'hA5);
      step(); #1 chk("bp_d2_stable", od[2], 8'hA5);
      send(1, 1, 8'h77); #1 chk("bp_ch1_rdy", in_ready, 1);
      step(); #1;
      chk("bp_v1", ov[1], 1); chk("bp_d1", od[1], 8'h77); chk("bp_d2_still", od[2], 8'hA5);
      ordy = 4'hF; send(1, 2, 8'h5A); #1 chk("bp_release_rdy", in_ready, 1);
      step(); #1;
      chk("bp_d2_new", od[2], 8'h5A); chk("bp_v2_new", ov[2], 1);
      in_valid = 1'b0;
      step(); #1;
      chk("bp_cnt2", oc[2], 3); chk("bp_cnt1", oc[1], 2);

      // Same-cycle drain and refill on channel 0
      ordy = 4'b1110;
      send(1, 0, 8'h01);
      step(); #1;
      chk("dr_v0", ov[0], 1); chk("dr_d0", od[0], 8'h01);
      ordy = 4'hF; send(1, 0, 8'h02); #1 chk("dr_rdy", in_ready, 1);
      step(); #1;
      chk("dr_d0_new", od[0], 8'h02); chk("dr_v0_new", ov[0], 1); chk("dr_cnt0", oc[0], 2);
      in_valid = 1'b0;
      step();

      // Counter saturation and clear on channel 3
      cnt_clear = 1'b1;
      step(); cnt_clear = 1'b0; #1 chk("sat_cleared", oc[3], 0);
      for (int i = 0; i < 5; i++) begin
         send(1, 3, 8'(8'h30 + i));
         step();
      end
      in_valid = 1'b0;
      step(); #1 chk("sat_cnt3", oc[3], 3);
      ordy = 4'b0111; send(1, 3, 8'hEE);
      step(); in_valid = 1'b0; #1 chk("sat_v3_full", ov[3], 1);
      cnt_clear = 1'b1; ordy = 4'hF;
      step(); cnt_clear = 1'b0; #1;
      chk("clr_cnt3", oc[3], 0); chk("clr_v3_drained", ov[3], 0); chk("clr_d3_hold", od[3], 8'hEE);

      // Reset in the middle of operation
      ordy = 4'h0;
      for (int s = 0; s < 4; s++) begin
         send(1, 2'(s), 8'(8'hC0 + s));
         step();
      end
      in_valid = 1'b0; #1 chk("mid_all_full", ov, 4'hF);
      rst = 1'b1; #1;
      chk("mid_rst_valid", ov, 4'h0);
      for (int k = 0; k < 4; k++) chk("mid_rst_data", od[k], 0);
      step(); rst = 1'b0;
      ordy = 4'hF; send(1, 1, 8'h9C);
      step(); #1;
      chk("post_v1", ov[1], 1); chk("post_d1", od[1], 8'h9C); chk("post_ov", ov, 4'b0010);
      in_valid = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
